// File: rtl/fwd_track_unit.sv
// Forwarding / hazard tracker.
// A shift pipeline of producer records {addr, we, tnew} follows each instruction
// from E onward. Every read port is resolved against it in the same cycle.
// The youngest matching stage decides the outcome:
//   - it forwards that stage's result, or
//   - it blocks the operand, and may request a stall.
module fwd_track_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned TNEW_W   = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic                         in_we,
  input  logic [TNEW_W-1:0]            in_tnew,
  input  logic [STAGES*DATA_W-1:0]     stage_data,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  input  logic [RD_PORTS*TNEW_W-1:0]   rd_tuse,
  input  logic [RD_PORTS*DATA_W-1:0]   rd_data_now,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data_fwd,
  output logic [RD_PORTS-1:0]          rd_ready,
  output logic                         stall_req,
  output logic [31:0]                  stall_cycles
);

  logic [ADDR_W-1:0] rec_addr [STAGES];
  logic [STAGES-1:0] rec_we;
  logic [TNEW_W-1:0] rec_tnew [STAGES];
  logic [RD_PORTS-1:0] hazard;

  // Record pipeline: stage 0 captures the instruction leaving D (or a bubble),
  // older stages shift with a saturating T_new countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        rec_addr[i] <= '0;
        rec_tnew[i] <= '0;
      end
      rec_we <= '0;
    end else begin
      if (stall_req || flush) begin
        rec_addr[0] <= '0;
        rec_we[0]   <= 1'b0;
        rec_tnew[0] <= '0;
      end else begin
        rec_addr[0] <= in_addr;
        rec_we[0]   <= in_we && (in_addr != '0);
        rec_tnew[0] <= in_tnew;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        rec_addr[i] <= rec_addr[i-1];
        rec_we[i]   <= rec_we[i-1];
        rec_tnew[i] <= (rec_tnew[i-1] == '0) ? '0 : rec_tnew[i-1] - TNEW_W'(1);
      end
    end
  end

  // Per-port resolution. Stages are scanned oldest first, so the youngest match
  // overwrites the result. A blocked young match therefore hides older stages.
  always_comb begin
    rd_data_fwd = rd_data_now;
    rd_ready    = '1;
    hazard      = '0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      for (int unsigned k = STAGES; k > 0; k--) begin
        if (rec_we[k-1] &&
            (rec_addr[k-1] == rd_addr[p*ADDR_W +: ADDR_W]) &&
            (rd_addr[p*ADDR_W +: ADDR_W] != '0)) begin
          if (rec_tnew[k-1] == '0) begin
            rd_data_fwd[p*DATA_W +: DATA_W] = stage_data[(k-1)*DATA_W +: DATA_W];
            rd_ready[p] = 1'b1;
            hazard[p]   = 1'b0;
          end else begin
            rd_data_fwd[p*DATA_W +: DATA_W] = rd_data_now[p*DATA_W +: DATA_W];
            rd_ready[p] = 1'b0;
            hazard[p]   = rec_tnew[k-1] > rd_tuse[p*TNEW_W +: TNEW_W];
          end
        end
      end
    end
  end

  assign stall_req = |hazard;

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall_req && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
